// File: rtl/seg7_pkg.sv
// seg7_pkg: seven-segment glyph constants and decoder state type.
//   Glyph constants use SEG encoding bit0=a .. bit6=g (dp not included).
//   They are shared with the hex counter's display encoder, so the decoder
//   inverts exactly the same table.
package seg7_pkg;

  localparam logic [6:0] NUM_0   = 7'h3f;
  localparam logic [6:0] NUM_1   = 7'h06;
  localparam logic [6:0] NUM_2   = 7'h5b;
  localparam logic [6:0] NUM_3   = 7'h4f;
  localparam logic [6:0] NUM_4   = 7'h66;
  localparam logic [6:0] NUM_5   = 7'h6d;
  localparam logic [6:0] NUM_6   = 7'h7d;
  localparam logic [6:0] NUM_7   = 7'h07;
  localparam logic [6:0] NUM_8   = 7'h7f;
  localparam logic [6:0] NUM_9   = 7'h6f;
  localparam logic [6:0] LETRA_A = 7'h77;
  localparam logic [6:0] LETRA_B = 7'h7c;
  localparam logic [6:0] LETRA_C = 7'h39;
  localparam logic [6:0] LETRA_D = 7'h5e;
  localparam logic [6:0] LETRA_E = 7'h79;
  localparam logic [6:0] LETRA_F = 7'h71;

  typedef enum logic [1:0] {IDLE, SETTLE, COMMIT, HOLD} seg7_dec_state_t;

endpackage

// File: rtl/seg7_decoder_hex_if.sv
// seg7_decoder_hex_if: bundle between the segment source and the decoder.
//   seg_in      8      segment pattern from the board switches (bit7 = dp)
//   digit       4      last decoded hex value
//   digit_valid 1      one-cycle pulse on digit update
//   invalid     1      last committed pattern was not a hex glyph
//   history     8      {previous digit, last digit}
//   err_count   ERR_W  saturating count of invalid commits
// master drives seg_in and observes results; slave is the decoder.
interface seg7_decoder_hex_if #(parameter int ERR_W = 4);
  logic [7:0]       seg_in;
  logic [3:0]       digit;
  logic             digit_valid;
  logic             invalid;
  logic [7:0]       history;
  logic [ERR_W-1:0] err_count;

  modport master (output seg_in,
                  input  digit, digit_valid, invalid, history, err_count);
  modport slave  (input  seg_in,
                  output digit, digit_valid, invalid, history, err_count);
endinterface

// File: rtl/seg7_glyph_to_hex.sv
// seg7_glyph_to_hex: combinational 7-segment glyph -> hex nibble lookup.
//   pattern  in   7   segments a..g
//   ok       out  1   pattern is one of the 16 hex glyphs (exact match)
//   nibble   out  4   decoded value, 0 when ok=0
module seg7_glyph_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       ok,
  output logic [3:0] nibble
);

  always_comb begin
    ok     = 1'b1;
    nibble = 4'h0;
    case (pattern)
      NUM_0:   nibble = 4'h0;
      NUM_1:   nibble = 4'h1;
      NUM_2:   nibble = 4'h2;
      NUM_3:   nibble = 4'h3;
      NUM_4:   nibble = 4'h4;
      NUM_5:   nibble = 4'h5;
      NUM_6:   nibble = 4'h6;
      NUM_7:   nibble = 4'h7;
      NUM_8:   nibble = 4'h8;
      NUM_9:   nibble = 4'h9;
      LETRA_A: nibble = 4'ha;
      LETRA_B: nibble = 4'hb;
      LETRA_C: nibble = 4'hc;
      LETRA_D: nibble = 4'hd;
      LETRA_E: nibble = 4'he;
      LETRA_F: nibble = 4'hf;
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_decoder_hex.sv
// seg7_decoder_hex: debounces a seven-segment pattern and decodes it back
// to a hex digit, keeping a 2-digit history and an invalid-glyph counter.
// On the board SWI feeds seg_in and LED shows history.
//   clk_2   in   single clock, all state on posedge
//   reset   in   asynchronous, active-high
//   bus     slave modport of seg7_decoder_hex_if (seg_in in, results out)
// Params: STABLE_CYCLES (>=1) cycles a nonzero pattern must be steady,
//         ERR_W width of the saturating error counter.
module seg7_decoder_hex
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 4
) (
  input logic              clk_2,
  input logic              reset,
  seg7_decoder_hex_if.slave bus
);

  localparam int              CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  seg7_dec_state_t  r_state;
  logic [6:0]       r_seg_q;
  logic [6:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_digit;
  logic             r_digit_valid;
  logic             r_invalid;
  logic [7:0]       r_history;
  logic [ERR_W-1:0] r_err_count;

  logic             w_ok;
  logic [3:0]       w_nibble;
  logic             w_unused_dp;

  // dp is deliberately dropped at the input register, so toggling it alone
  // can never look like a new pattern.
  assign w_unused_dp = bus.seg_in[7];

  // Decode the candidate, which equals seg_q for the whole debounce window.
  seg7_glyph_to_hex u_glyph (
    .pattern (r_cand),
    .ok      (w_ok),
    .nibble  (w_nibble)
  );

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_seg_q       <= '0;
      r_cand        <= '0;
      r_cnt         <= '0;
      r_digit       <= '0;
      r_digit_valid <= 1'b0;
      r_invalid     <= 1'b0;
      r_history     <= '0;
      r_err_count   <= '0;
    end else begin
      r_seg_q       <= bus.seg_in[6:0];
      r_digit_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_seg_q != 7'h00) begin
            r_cand  <= r_seg_q;
            r_cnt   <= '0;
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_seg_q == 7'h00) begin
            r_state <= IDLE;
          end else if (r_seg_q != r_cand) begin
            // glitch: restart the window on the new pattern
            r_cand <= r_seg_q;
            r_cnt  <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= COMMIT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        COMMIT: begin
          if (w_ok) begin
            r_digit       <= w_nibble;
            r_history     <= {r_history[3:0], w_nibble};
            r_digit_valid <= 1'b1;
            r_invalid     <= 1'b0;
          end else begin
            r_invalid <= 1'b1;
            if (r_err_count != '1)
              r_err_count <= r_err_count + ERR_W'(1);
          end
          r_state <= HOLD;
        end
        HOLD: begin
          // the held glyph is not recommitted; it must change or blank first
          if (r_seg_q == 7'h00) begin
            r_state <= IDLE;
          end else if (r_seg_q != r_cand) begin
            r_cand  <= r_seg_q;
            r_cnt   <= '0;
            r_state <= SETTLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.digit       = r_digit;
  assign bus.digit_valid = r_digit_valid;
  assign bus.invalid     = r_invalid;
  assign bus.history     = r_history;
  assign bus.err_count   = r_err_count;

endmodule

// File: tb/tb_seg7_decoder_hex.sv
// tb_seg7_decoder_hex: directed, table-driven bench for seg7_decoder_hex
// with STABLE_CYCLES=4, plus hand sequences for reset latency, error
// saturation and reset during debounce.
module tb_seg7_decoder_hex;

  logic clk_2 = 1'b0;
  logic reset = 1'b1;

  seg7_decoder_hex_if #(.ERR_W(4)) bus ();

  seg7_decoder_hex #(.STABLE_CYCLES(4), .ERR_W(4)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    logic [7:0] seg;
    int         cyc;
    int         pulses;
    logic [3:0] digit;
    logic       inv;
    logic [7:0] hist;
    logic [3:0] err;
  } vec_t;

  vec_t vecs [0:10];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock; sample 1ns after the rising edge, return pulse seen
  task automatic step(output bit pulse);
    @(posedge clk_2);
    #1;
    pulse = bus.digit_valid;
  endtask

  task automatic hold_for(input logic [7:0] seg, input int cyc, output int pulses);
    bit p;
    bus.seg_in = seg;
    pulses = 0;
    for (int c = 0; c < cyc; c++) begin
      step(p);
      if (p) pulses++;
    end
  endtask

  task automatic run_vec(input int idx);
    int np;
    hold_for(vecs[idx].seg, vecs[idx].cyc, np);
    chk($sformatf("v%0d pulses", idx),  np,                  vecs[idx].pulses);
    chk($sformatf("v%0d digit", idx),   int'(bus.digit),     int'(vecs[idx].digit));
    chk($sformatf("v%0d invalid", idx), int'(bus.invalid),   int'(vecs[idx].inv));
    chk($sformatf("v%0d history", idx), int'(bus.history),   int'(vecs[idx].hist));
    chk($sformatf("v%0d err", idx),     int'(bus.err_count), int'(vecs[idx].err));
  endtask

  initial begin
    bit p;
    int np;
    int first_pulse;

    //          seg    cyc pul dig inv hist   err
    vecs[0]  = '{8'h06, 10, 1, 4'h1, 1'b0, 8'h01, 4'h0};
    vecs[1]  = '{8'h00, 10, 0, 4'h1, 1'b0, 8'h01, 4'h0};
    vecs[2]  = '{8'h71, 10, 1, 4'hf, 1'b0, 8'h1f, 4'h0};
    vecs[3]  = '{8'h06,  2, 0, 4'hf, 1'b0, 8'h1f, 4'h0};
    vecs[4]  = '{8'h5b,  1, 0, 4'hf, 1'b0, 8'h1f, 4'h0};
    vecs[5]  = '{8'h4f, 10, 1, 4'h3, 1'b0, 8'hf3, 4'h0};
    vecs[6]  = '{8'h7e, 10, 0, 4'h3, 1'b1, 8'hf3, 4'h1};
    vecs[7]  = '{8'h00,  4, 0, 4'h3, 1'b1, 8'hf3, 4'hf};
    vecs[8]  = '{8'hbf, 10, 1, 4'h0, 1'b0, 8'h30, 4'hf};
    vecs[9]  = '{8'h3f, 10, 0, 4'h0, 1'b0, 8'h30, 4'hf};
    vecs[10] = '{8'hbf, 10, 0, 4'h0, 1'b0, 8'h30, 4'hf};

    // Test 1: reset held with a valid glyph, then exact commit latency
    bus.seg_in = 8'h3f;
    reset = 1'b1;
    np = 0;
    for (int c = 0; c < 20; c++) begin
      step(p);
      if (p) np++;
    end
    chk("rst pulses", np, 0);
    chk("rst digit", int'(bus.digit), 0);
    chk("rst invalid", int'(bus.invalid), 0);
    chk("rst history", int'(bus.history), 0);
    chk("rst err", int'(bus.err_count), 0);
    reset = 1'b0;
    np = 0;
    first_pulse = -1;
    // index 0 is the first sampling edge after release
    for (int c = 0; c < 12; c++) begin
      step(p);
      if (p) begin
        np++;
        if (first_pulse < 0) first_pulse = c;
      end
    end
    chk("t1 pulses", np, 1);
    chk("t1 latency", first_pulse, 6);
    chk("t1 digit", int'(bus.digit), 0);
    chk("t1 history", int'(bus.history), 0);

    // Tests 2-4: table
    for (int i = 0; i <= 6; i++) run_vec(i);

    // Test 4 continued: 16 blank/invalid pairs, counter saturates at F
    for (int k = 1; k <= 16; k++) begin
      hold_for(8'h00, 3, np);
      hold_for(8'h7e, 8, np);
      chk($sformatf("sat%0d pulses", k), np, 0);
      chk($sformatf("sat%0d err", k), int'(bus.err_count), (1 + k > 15) ? 15 : 1 + k);
    end
    chk("sat digit", int'(bus.digit), 3);
    chk("sat invalid", int'(bus.invalid), 1);

    // Test 5: dp ignored
    for (int i = 7; i <= 10; i++) run_vec(i);

    // Test 6: reset two cycles into SETTLE aborts the commit
    hold_for(8'h00, 3, np);
    bus.seg_in = 8'h66;
    np = 0;
    for (int c = 0; c < 3; c++) begin
      step(p);
      if (p) np++;
    end
    reset = 1'b1;
    #1;
    chk("t6 async digit", int'(bus.digit), 0);
    chk("t6 async valid", int'(bus.digit_valid), 0);
    chk("t6 async history", int'(bus.history), 0);
    chk("t6 async err", int'(bus.err_count), 0);
    chk("t6 async invalid", int'(bus.invalid), 0);
    for (int c = 0; c < 2; c++) begin
      step(p);
      if (p) np++;
    end
    chk("t6 no pulse", np, 0);
    reset = 1'b0;
    hold_for(8'h66, 10, np);
    chk("t6 pulses", np, 1);
    chk("t6 digit", int'(bus.digit), 4);
    chk("t6 history", int'(bus.history), 8'h04);
    chk("t6 invalid", int'(bus.invalid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
